mem_access_ctrl: RTL
====================

# mem_access_ctrl

Sequencing controller for the MEM stage's data memory. Accepts one load/store per MEM-stage instruction, drives the word-wide synchronous dmem block RAM, performs read-modify-write for byte/halfword stores and sign/zero extension for sub-word loads, and reports completion to the stage through a `ready_go` handshake. Sits between the MEM pipeline register outputs and the dmem RAM, replacing the stage's hard-wired `ready_go = 1`.

## Interface
Parameters:
- `ADDR_W`, 11, RAM word-address width; RAM index is `req_addr[ADDR_W+1:2]`.

Ports:
- `clk` in 1: the single clock; RAM shares it.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: MEM stage holds a valid memory instruction (`mem_valid & is_mem_op`).
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `req_sign` in 1: sign-extend sub-word load.
- `req_addr` in 32: mapped physical address.
- `req_wdata` in 32: store data, right-aligned.
- `ex_no_write` in 1: exception in MEM or WB; suppresses all RAM writes.
- `flush` in 1: pipeline flush; abort current sequence.
- `wb_allowin` in 1: WB stage accepts this cycle.
- `ready_go` out 1: request complete; MEM may hand off.
- `rdata` out 32: extended load result, valid while `ready_go`.
- `addr_err` out 1: misaligned access; valid while `ready_go`.
- `ram_addr` out ADDR_W: RAM word address.
- `ram_din` out 32: RAM write data.
- `ram_we` out 1: RAM write enable.
- `ram_dout` in 32: RAM read data, 1-cycle synchronous latency.

## Operation
- States: IDLE, LOAD_RD, RMW, HOLD. Reset → IDLE; hold register (`hold_data`, `hold_err`) resets to 0.
- Misalignment (combinational, IDLE only): half with `addr[0]=1`, word with `addr[1:0]!=0` → `addr_err=1`, `ready_go=1` in the same cycle, no RAM access, no state change unless `!wb_allowin` (→ HOLD).
- `ex_no_write=1` in IDLE with a store: no RAM access, `ready_go=1`, `addr_err=0`.
- IDLE + aligned load: `ram_addr` ← `req_addr`, → LOAD_RD.
- LOAD_RD: `rdata` = lane of `ram_dout` extended. Byte lane = `addr[1:0]`, half lane = `addr[1]`, little-endian. `req_sign` selects sign or zero fill. `ready_go=1`; → IDLE if `wb_allowin`, else latch `rdata` into `hold_data` → HOLD.
- IDLE + aligned word store: `ram_we=1`, `ram_din=req_wdata`, `ready_go=1` in the same cycle; → HOLD if `!wb_allowin`.
- IDLE + aligned byte/half store: issue read, → RMW.
- RMW: `ram_din` = `ram_dout` with the addressed byte/half lane replaced by `req_wdata[7:0]`/`[15:0]`. `ram_we = !ex_no_write`, `ready_go=1`; → IDLE or HOLD as above.
- HOLD: `ready_go=1`, `rdata=hold_data`, `addr_err=hold_err`, `ram_we=0`; → IDLE when `wb_allowin`. HOLD never re-writes RAM.
- Ready signalling:
  - `ready_go=0` whenever `req_valid=0` in IDLE.
  - `ready_go=0` in IDLE for an aligned load or sub-word store.
- Flush: `flush=1` in any state forces `ram_we=0` and `ready_go=0`; next state IDLE. `flush` overrides everything except `rst`.
- `rst` asserted mid-sequence: `ram_we=0` that cycle, next state IDLE, hold register cleared.
- Request inputs are stable while `req_valid && !(ready_go && wb_allowin)`; the controller does not latch them.

## Timing
- Word store, misaligned access, suppressed store: 0 extra cycles (`ready_go` same cycle).
- Load: 1 extra cycle (`ready_go` in the cycle after issue).
- Sub-word store: 1 extra cycle; write occurs in the RMW cycle.
- Each instruction causes at most one RAM write.
- `ram_we` is asserted only in IDLE (word store) or RMW, and never while `rst` or `flush`.
- Back-to-back: IDLE completion with `wb_allowin` lets the next request start the following cycle. No bubble after LOAD_RD/RMW → IDLE.

## Test plan
- Word store `addr=0x10`, `wdata=0xDEADBEEF`, `wb_allowin=1` → `ram_we=1` in cycle 0, `ram_addr=4`, `ready_go=1`. A following word load of `0x10` → `rdata=0xDEADBEEF` one cycle later.
- RAM word[4]=`0x11223344`; byte store `addr=0x12`, `wdata=0xAA` → `ready_go` in cycle 1, RAM word[4]=`0x11AA3344`. Signed byte load `addr=0x12` → `0xFFFFFFAA`; unsigned → `0x000000AA`.
- Half load `addr=0x11` → `addr_err=1`, `ready_go=1` in cycle 0, no RAM access. Word store `addr=0x16` → `addr_err=1`, `ram_we` never asserted.
- Halfword store `addr=0x12`, `wdata=0x5566`, `ex_no_write` rising in the RMW cycle → `ram_we=0`, word[4] unchanged, `ready_go=1`.
- Load with `wb_allowin=0` for 3 cycles → HOLD, `rdata` stable, `ram_we=0`. Releasing `wb_allowin` → IDLE next cycle, next request proceeds immediately.
- `flush` in RMW, then separately `rst` in LOAD_RD → no write, state IDLE next cycle, `ready_go=0`, `rdata=0` in HOLD-cleared state.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage dmem sequencer with sub-word RMW stores, extended loads and a ready_go handshake.
module mem_access_ctrl #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              ex_no_write,
  input  logic              flush,
  input  logic              wb_allowin,
  output logic              ready_go,
  output logic [31:0]       rdata,
  output logic              addr_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout
);
  typedef enum logic [1:0] {IDLE, LOAD_RD, RMW, HOLD} state_t;
  state_t state, nxt;
  logic [31:0] hold_data, ext, merged, shifted, mask;
  logic [4:0] sh;
  logic hold_err, mis, done_now, unused;
  assign unused = ^req_addr[31:ADDR_W+2];
  // Aligned half offsets are multiples of 16, so one byte-granular shift serves both sizes.
  assign sh = {req_addr[1:0], 3'b000};
  assign shifted = ram_dout >> sh;
  assign mask = (req_size == 2'd0 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
  assign merged = (ram_dout & ~mask) | ((req_wdata << sh) & mask);
  assign ext = req_size == 2'd0 ? {{24{req_sign & shifted[7]}}, shifted[7:0]} :
               req_size == 2'd1 ? {{16{req_sign & shifted[15]}}, shifted[15:0]} : ram_dout;
  assign mis = (req_size == 2'd1 & req_addr[0]) | (req_size[1] & |req_addr[1:0]);
  assign done_now = mis | (req_we & (ex_no_write | req_size[1]));
  assign ram_addr = req_addr[ADDR_W+1:2];
  assign ram_din = state == RMW ? merged : req_wdata;
  always_comb begin
    nxt = state;
    ready_go = 1'b0;
    ram_we = 1'b0;
    addr_err = 1'b0;
    rdata = 32'd0;
    case (state)
      IDLE: if (req_valid) begin
        if (done_now) begin
          ready_go = 1'b1;
          addr_err = mis;
          ram_we = req_we & req_size[1] & !mis & !ex_no_write;
          nxt = wb_allowin ? IDLE : HOLD;
        end else nxt = req_we ? RMW : LOAD_RD;
      end
      LOAD_RD: begin
        ready_go = 1'b1;
        rdata = ext;
        nxt = wb_allowin ? IDLE : HOLD;
      end
      RMW: begin
        ready_go = 1'b1;
        ram_we = !ex_no_write;
        nxt = wb_allowin ? IDLE : HOLD;
      end
      default: begin
        ready_go = 1'b1;
        rdata = hold_data;
        addr_err = hold_err;
        nxt = wb_allowin ? IDLE : HOLD;
      end
    endcase
    if (flush) begin
      ready_go = 1'b0;
      nxt = IDLE;
    end
    if (flush || rst) ram_we = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hold_data <= 32'd0;
      hold_err <= 1'b0;
    end else begin
      state <= nxt;
      if (state != HOLD && nxt == HOLD) begin
        hold_data <= rdata;
        hold_err <= addr_err;
      end
    end
  end
endmodule
